// File: rtl/bitser_sub_pkg.sv
// -----------------------------------------------------------------------------
// bitser_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - state_e    : FSM state encoding (2'd3 is unused and recovers to IDLE)
//   - signed_ovf : two's-complement overflow rule for A - B
// -----------------------------------------------------------------------------
package bitser_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Subtraction overflows only when the operand signs differ and the
    // result sign disagrees with the minuend sign.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/bitser_sub_bit1sub.sv
// -----------------------------------------------------------------------------
// bit1sub
// Purely combinational 1-bit full subtractor computing a - b - bin.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   out       : difference bit
//   bout      : borrow out
// -----------------------------------------------------------------------------
module bit1sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic out,
    output logic bout
);

    assign out  = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a == b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bitser_sub.sv
// -----------------------------------------------------------------------------
// bitser_sub
// Bit-serial WIDTH-bit subtractor computing A - B, LSB first, one bit/clock.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only while ready=1
//   a, b       : minuend / subtrahend, sampled on the accepting edge
//   ready      : high in IDLE
//   done       : one-cycle pulse when the result is valid
//   diff       : A - B modulo 2^WIDTH
//   bout       : final borrow (unsigned A < B)
//   ovf        : signed two's-complement overflow
// -----------------------------------------------------------------------------
module bitser_sub
    import bitser_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             d_s;
    logic             bo_s;

    // Single bit slice shared by every serial step.
    bit1sub u_slice (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .out  (d_s),
        .bout (bo_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // diff is deliberately left alone; it shifts out during RUN.
                    sa_d     = a;
                    sb_d     = b;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_d     = {1'b0, sa_q[WIDTH-1:1]};
                sb_d     = {1'b0, sb_q[WIDTH-1:1]};
                diff_d   = {d_s, diff_q[WIDTH-1:1]};
                borrow_d = bo_s;
                if (cnt_q == CNT_LAST) begin
                    // Last slice: d_s is the result MSB, bo_s the final borrow.
                    bout_d  = bo_s;
                    ovf_d   = signed_ovf(a_msb_q, b_msb_q, d_s);
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake outputs decode directly from the registered state.
    assign ready = (state_q == ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_bitser_sub.sv
// -----------------------------------------------------------------------------
// tb_bitser_sub
// Directed bench for bitser_sub (WIDTH=8). Stimulus pushes hand-computed
// expected results into a queue; a negedge monitor pops and compares them
// whenever done is seen, including the accept-to-done latency.
// -----------------------------------------------------------------------------
module tb_bitser_sub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    bitser_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        int               acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_single_pulse", {31'd0, prev_done}, 32'd0);
            check("done_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", {24'd0, diff}, {24'd0, e.diff});
                check("bout", {31'd0, bout}, {31'd0, e.bout});
                check("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
                check("latency", cyc - e.acc, WIDTH);
            end
        end
        prev_done = done;
    end

    // Called at a negedge; waits for ready, then presents one start pulse.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
        a     = av;
        b     = bv;
        start = 1'b1;
        sb_q.push_back('{ed, eb, eo, cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for all outstanding results, then confirm they hold.
    task automatic wait_idle(input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb_q.size(), 0);
        repeat (2) @(negedge clk);
        check("hold_diff", {24'd0, diff}, {24'd0, ed});
        check("hold_bout", {31'd0, bout}, {31'd0, eb});
        check("hold_ovf",  {31'd0, ovf},  {31'd0, eo});
        check("hold_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [7:0] va [5] = '{8'h35, 8'h12, 8'h80, 8'h7F, 8'h00};
    logic [7:0] vb [5] = '{8'h12, 8'h35, 8'h01, 8'hFF, 8'h00};
    logic [7:0] vd [5] = '{8'h23, 8'hDD, 8'h7F, 8'h80, 8'h00};
    logic       vbo[5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       vov[5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_diff",  {24'd0, diff},  32'd0);
        check("rst_bout",  {31'd0, bout},  32'd0);
        check("rst_ovf",   {31'd0, ovf},   32'd0);

        // Basic vectors.
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], vd[i], vbo[i], vov[i]);
            check("busy_ready", {31'd0, ready}, 32'd0);
            wait_idle(vd[i], vbo[i], vov[i]);
        end

        // Start held high from RUN cycle 3 through DONE: ignored until IDLE.
        issue(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        k = cyc;
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'h01;
        start = 1'b1;
        sb_q.push_back('{8'hFE, 1'b0, 1'b0, k + 10});
        while (cyc < k + 10) begin
            @(negedge clk);
            if (cyc == k + 9) check("idle_after_done", {31'd0, ready}, 32'd1);
        end
        start = 1'b0;
        check("second_accepted", {31'd0, ready}, 32'd0);
        wait_idle(8'hFE, 1'b0, 1'b0);

        // Reset during RUN discards the operation.
        issue(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_done",  {31'd0, done},  32'd0);
        check("mid_rst_diff",  {24'd0, diff},  32'd0);
        check("mid_rst_bout",  {31'd0, bout},  32'd0);
        check("mid_rst_ovf",   {31'd0, ovf},   32'd0);
        repeat (12) @(negedge clk);
        issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        wait_idle(8'h7F, 1'b0, 1'b1);

        check("queue_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
